// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int              ERRCNT_W   = 16;
    localparam logic [15:0]     ERRCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request scanning cyclically
// from a start index, optionally skipping one excluded index.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_start,
    input  logic            i_excl_en,
    input  logic [IW-1:0]   i_excl_idx,
    output logic            o_valid,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx
);

    int j;

    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        j        = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_start) + k) % NREQ;
            if (!o_valid && i_req[j] && !(i_excl_en && (IW'(j) == i_excl_idx))) begin
                o_valid     = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the async FIFO write port.
// Optional write-error counter enabled by defining FIFO_WR_ARB_ERRCNT_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DW    = 8,
    parameter  int BURST = 4,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic               wclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    input  logic               full,
    input  logic               w_er,
    output logic               w_en,
    output logic [DW-1:0]      wdata,
    output logic               busy,
    output logic [IW-1:0]      owner,
    output logic [15:0]        err_cnt
);

    arb_state_t       r_st;
    arb_state_t       w_st_nxt;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    w_rr_nxt;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    w_owner_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [8:0]       w_cnt_inc;
    logic [IW-1:0]    w_owner_inc;
    logic [IW-1:0]    w_pick_inc;
    logic [NREQ-1:0]  w_gnt_raw;
    logic [IW-1:0]    w_sel;
    logic             w_take;
    logic             w_pick_valid;
    logic [NREQ-1:0]  w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_is_lock;

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
        return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
    endfunction

    assign w_is_lock   = (r_st == LOCK);
    assign w_owner_inc = inc_wrap(r_owner);
    assign w_pick_inc  = inc_wrap(w_pick_idx);
    assign w_cnt_inc   = {1'b0, r_cnt} + 9'd1;

    // In LOCK the scan starts after the owner and skips it, so a release hands over in the same cycle.
    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req      (req),
        .i_start    (w_is_lock ? w_owner_inc : r_rr_ptr),
        .i_excl_en  (w_is_lock),
        .i_excl_idx (r_owner),
        .o_valid    (w_pick_valid),
        .o_onehot   (w_pick_onehot),
        .o_idx      (w_pick_idx)
    );

    always_comb begin
        w_st_nxt    = r_st;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_gnt_raw   = '0;
        w_sel       = r_owner;
        w_take      = 1'b0;
        case (r_st)
            IDLE: begin
                w_take = !full && w_pick_valid;
            end
            LOCK: begin
                if (req[r_owner]) begin
                    if (!full) begin
                        w_gnt_raw[r_owner] = 1'b1;
                        w_cnt_nxt          = w_cnt_inc[7:0];
                        if (w_cnt_inc == 9'(BURST)) begin
                            w_st_nxt = IDLE;
                            w_rr_nxt = w_owner_inc;
                        end
                    end
                end else if (!full && w_pick_valid) begin
                    w_take = 1'b1;
                end else begin
                    w_st_nxt = IDLE;
                    w_rr_nxt = w_owner_inc;
                end
            end
            default: w_st_nxt = IDLE;
        endcase

        // A fresh burst starts from the picked requester.
        if (w_take) begin
            w_gnt_raw   = w_pick_onehot;
            w_sel       = w_pick_idx;
            w_owner_nxt = w_pick_idx;
            w_cnt_nxt   = 8'd1;
            if (BURST > 1) begin
                w_st_nxt = LOCK;
            end else begin
                w_st_nxt = IDLE;
                w_rr_nxt = w_pick_inc;
            end
        end
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            r_st     <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
        end else begin
            r_st     <= w_st_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Grant is gated by reset so outputs drop asynchronously even with requests pending.
    assign gnt   = rst ? w_gnt_raw : '0;
    assign w_en  = |gnt;
    assign wdata = w_en ? req_data[w_sel*DW +: DW] : '0;
    assign busy  = w_is_lock;
    assign owner = r_owner;

`ifdef FIFO_WR_ARB_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_er && (r_err_cnt != ERRCNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused;
    assign w_unused = w_er;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST=4).
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        full;
    logic        w_er;
    logic        w_en;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  owner;
    logic [15:0] err_cnt;

    logic [7:0]  dat [4];
    int          checks   = 0;
    int          failures = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .wclk     (wclk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .full     (full),
        .w_er     (w_er),
        .w_en     (w_en),
        .wdata    (wdata),
        .busy     (busy),
        .owner    (owner),
        .err_cnt  (err_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [3:0] eg, input logic eb);
        logic [7:0] ed;
        ed = 8'h00;
        for (int i = 0; i < 4; i++) if (eg[i]) ed = dat[i];
        chk1({tag, ".gnt"},   32'(gnt),   32'(eg));
        chk1({tag, ".w_en"},  32'(w_en),  32'(|eg));
        chk1({tag, ".wdata"}, 32'(wdata), 32'(ed));
        chk1({tag, ".busy"},  32'(busy),  32'(eb));
    endtask

    // Check mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] eg, input logic eb);
        #2;
        chk_cyc(tag, eg, eb);
        @(posedge wclk);
        #1;
    endtask

    initial begin
        dat[0] = 8'h3C; dat[1] = 8'hA5; dat[2] = 8'h5A; dat[3] = 8'hC3;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        rst  = 1'b0;
        req  = 4'hF;
        full = 1'b0;
        w_er = 1'b0;

        // Reset held with all requests asserted
        repeat (4) begin
            @(posedge wclk);
            #1;
            chk_cyc("reset", 4'b0000, 1'b0);
            chk1("reset.err_cnt", 32'(err_cnt), 32'h0);
            chk1("reset.owner",   32'(owner),   32'h0);
        end
        rst = 1'b1;

        // Four-write bursts rotating 0,1,2,3,0 with no bubble
        for (int k = 0; k < 20; k++) begin
            cyc("burst", 4'b0001 << ((k / 4) % 4), (k % 4) != 0);
        end
        req = 4'b0000;
        cyc("idle_noreq", 4'b0000, 1'b0);

        // Early release from 2 to 3 (rr_ptr is 1 here)
        req = 4'b1100;
        cyc("early", 4'b0100, 1'b0);
        cyc("early", 4'b0100, 1'b1);
        req = 4'b1000;
        cyc("early_handoff", 4'b1000, 1'b1);
        chk1("early.owner", 32'(owner), 32'h3);
        cyc("early", 4'b1000, 1'b1);
        cyc("early", 4'b1000, 1'b1);
        cyc("early", 4'b1000, 1'b1);
        req = 4'b0000;
        cyc("early_end", 4'b0000, 1'b0);

        // Full stall mid-burst: owner 1 after two writes
        req = 4'b0010;
        cyc("stall_pre", 4'b0010, 1'b0);
        cyc("stall_pre", 4'b0010, 1'b1);
        req  = 4'b1011;
        full = 1'b1;
        repeat (3) cyc("stall", 4'b0000, 1'b1);
        chk1("stall.owner", 32'(owner), 32'h1);
        full = 1'b0;
        cyc("resume", 4'b0010, 1'b1);
        cyc("resume", 4'b0010, 1'b1);
        cyc("rotate", 4'b1000, 1'b0);
        req = 4'b0000;
        cyc("release_none", 4'b0000, 1'b1);
        req  = 4'hF;
        full = 1'b1;
        cyc("idle_full", 4'b0000, 1'b0);
        full = 1'b0;

        // Asynchronous reset while gnt[2] is high
        req = 4'b0100;
        cyc("pre_rst", 4'b0100, 1'b0);
        #2;
        chk_cyc("pre_rst", 4'b0100, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_cyc("rst_mid", 4'b0000, 1'b0);
        chk1("rst_mid.owner", 32'(owner), 32'h0);
        repeat (2) @(posedge wclk);
        #1;
        rst = 1'b1;
        req = 4'hF;
        cyc("post_rst", 4'b0001, 1'b0);
        cyc("post_rst", 4'b0001, 1'b1);
        req = 4'b0000;
        cyc("post_rst_rel", 4'b0000, 1'b1);
        cyc("post_rst_idle", 4'b0000, 1'b0);

        // Write-error counter
        w_er = 1'b1;
        repeat (5) @(posedge wclk);
        #1;
        w_er = 1'b0;
        #2;
`ifdef FIFO_WR_ARB_ERRCNT_EN
        chk1("err_cnt5", 32'(err_cnt), 32'd5);
        w_er = 1'b1;
        repeat (65529) @(posedge wclk);
        #1;
        w_er = 1'b0;
        #2;
        chk1("err_cnt_fffe", 32'(err_cnt), 32'hFFFE);
        w_er = 1'b1;
        @(posedge wclk);
        #1;
        chk1("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
        repeat (5) @(posedge wclk);
        #1;
        w_er = 1'b0;
        chk1("err_cnt_hold", 32'(err_cnt), 32'hFFFF);
`else
        chk1("err_cnt_off", 32'(err_cnt), 32'h0);
`endif
        chk1("err_gnt", 32'(gnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO among `NREQ` producers in the `wclk` domain. It picks one requester per cycle using round-robin priority with bounded burst locking. It drives the FIFO `w_en`/`wdata` and never issues a write while `full` is high. It sits directly in front of the FIFO write port, beside the producer logic, and replaces direct testbench drive of `w_en`/`wdata`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `DW`, 8: data width; equals the FIFO data width.
- `BURST`, 4: maximum consecutive writes by one owner before a forced release, 1..255.

Ports:
- `wclk`  in  1  write-domain clock. The block is single-clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `req`  in  NREQ  per-requester write request. Held until granted.
- `req_data`  in  NREQ*DW  requester data. Slice i is `[i*DW +: DW]`.
- `gnt`  out  NREQ  one-hot grant. Means the write happens this cycle.
- `full`  in  1  FIFO full, already in the `wclk` domain.
- `w_er`  in  1  FIFO write-error pulse.
- `w_en`  out  1  FIFO write enable.
- `wdata`  out  DW  FIFO write data.
- `busy`  out  1  high while in the LOCK state.
- `owner`  out  $clog2(NREQ)  current or last owner index.
- `err_cnt`  out  16  write-error count (see Configuration).

## Operation
Registered state:
- FSM `st`: IDLE or LOCK.
- `rr_ptr`: next-priority index.
- `owner`.
- Burst counter `cnt`, 8 bits.

Grant logic is combinational from the registered state plus `req`/`full`.

Arbitration (PICK):
- Choose the first i with `req[i]=1`, scanning cyclically from `rr_ptr`.

IDLE:
- If `full=1` or `req=0`: no grant; stay in IDLE.
- Otherwise PICK yields i. Then `gnt[i]=1`, `owner<=i`, `cnt<=1`.
  - Next state is LOCK if `BURST>1`.
  - Otherwise stay in IDLE and set `rr_ptr<=i+1` (mod NREQ).

LOCK:
- `req[owner]=1` and `full=1`: stall. No grant, state unchanged, `cnt` held.
- `req[owner]=1` and `full=0`: grant owner, `cnt<=cnt+1`.
  - If `cnt+1==BURST`: go to IDLE, `rr_ptr<=owner+1` (mod NREQ).
- `req[owner]=0`: release in the same cycle.
  - Run PICK from `owner+1`, excluding owner, exactly as IDLE does.
  - The new owner, if any, starts a fresh burst with `cnt<=1`.
  - If none qualifies: go to IDLE, `rr_ptr<=owner+1`.

Output rules:
- `w_en = |gnt`.
- `wdata` = slice of the granted requester when `w_en=1`; otherwise 0.
- `busy = (st==LOCK)`.

## Timing
- Zero-cycle grant: a write lands on the same `wclk` edge that `gnt` is high.
- `full` is sampled combinationally: `full=1` forces `gnt=0` and `w_en=0` in that cycle, in every state.
- Throughput is one write per cycle while `full=0` and any `req` is high. The IDLE↔LOCK transitions never insert a bubble.
- Requesters drop `req` or present new data in the cycle after `gnt`.
- Reset values (held while `rst=0`):
  - `st`=IDLE, `rr_ptr`=0, `owner`=0, `cnt`=0.
  - `gnt`=0, `w_en`=0, `wdata`=0, `busy`=0, `err_cnt`=0.
- Reset asserted mid-burst: outputs drop to their reset values immediately, asynchronously. After release the block starts in IDLE with priority at index 0.
- `cnt` never exceeds `BURST`.
- `rr_ptr` wraps from NREQ-1 to 0.
- A single requester with `req` stuck at 1 is re-granted after release with no bubble, because PICK from `rr_ptr` wraps back to it.

## Configuration
- `FIFO_WR_ARB_ERRCNT_EN` defined:
  - `err_cnt` increments by 1 on every `wclk` edge where `w_er=1`.
  - It saturates at 16'hFFFF and resets to 0.
- Not defined:
  - `err_cnt` is tied to 0.
  - `w_er` is ignored.
  - The port list is identical either way.

## Structure
- Package `fifo_arb_pkg` holds:
  - enum `arb_state_t` {IDLE, LOCK};
  - localparam `ERRCNT_W`=16;
  - localparam `ERRCNT_MAX`=16'hFFFF.
- Sub-module `rr_pick` (params `NREQ`):
  - Inputs: `req` vector, start index, exclude-enable, exclude index.
  - Outputs: `valid` and one-hot/index of the pick.
  - Purely combinational.
  - The arbiter instantiates it once.

## Test plan
- Reset: hold `rst=0` for 4 cycles with `req=4'hF` → `gnt=0`, `w_en=0`, `wdata=0`, `err_cnt=0`. The first grant after release goes to index 0.
- Burst/rotation: `req=4'hF` held, `BURST=4`, `full=0` → 4 writes from 0, then 4 from 1, 2, 3, 0. `w_en=1` every cycle with no bubble.
- Early release: only `req[2]` and `req[3]` high; drop `req[2]` after 2 grants → `gnt[3]` in the very next cycle; `busy` stays 1.
- Full stall: `full=1` for 3 cycles mid-burst (owner 1, `cnt=2`) → `gnt=0` and `w_en=0` for those cycles. When full clears, owner 1 resumes with 2 writes left.
- Reset mid-burst: assert `rst=0` asynchronously while `gnt[2]=1` → `gnt`/`w_en` drop before the next edge. After release, IDLE and priority restart at index 0.
- Error counter (macro defined): pulse `w_er` for 5 cycles → `err_cnt=5`. Preload near saturation and continue pulsing → holds 16'hFFFF. With the macro undefined → `err_cnt=0`.
